uart_time_report: RTL

- Transmit-side counterpart to the UART command decoder: formats the currently displayed time as ASCII and streams it byte-by-byte to the UART transmitter.
- Sits between the mux output (hour/min/sec/msec bus) and the UART TX core.
- A one-cycle request captures a snapshot of the time, which is then sent as "HH:MM:SS.CC" plus a line terminator.

---
 rtl/uart_time_report_pkg.sv | 32 +++
 rtl/uart_time_report_if.sv | 17 +
 rtl/uart_time_report_bin2ascii2.sv | 22 ++
 rtl/uart_time_report.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/uart_time_report_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_report_pkg : shared constants and FSM encoding for uart_time_report
// Rev 1.0
// ---------------------------------------------------------------------------
package uart_report_pkg;

  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_DOT   = 8'h2E;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  localparam logic [3:0] LAST_IDX_CRLF = 4'd12;
  localparam logic [3:0] LAST_IDX_LF   = 4'd11;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SNAP      = 3'd1;
  localparam logic [2:0] ST_SEND      = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_NEXT      = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_SNAP      = ST_SNAP,
    S_SEND      = ST_SEND,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_NEXT      = ST_NEXT
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_time_report_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_time_report_if : byte handshake between the report formatter and TX core
// Rev 1.0
// ---------------------------------------------------------------------------
interface uart_time_report_if;

  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  modport master (output tx_start, output tx_data, input tx_busy, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx_busy, output tx_done);

endinterface
`default_nettype wire

// File: rtl/uart_time_report_bin2ascii2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bin2ascii2 : 0..99 value (larger values clamp to 99) to two ASCII digits
// Rev 1.0
// ---------------------------------------------------------------------------
module bin2ascii2 (
  input  wire  [6:0] i_val,
  output logic [7:0] o_tens,
  output logic [7:0] o_ones
);
  import uart_report_pkg::*;

  logic [7:0] w_val;
  logic [7:0] w_tens;

  assign w_val  = (i_val > 7'd99) ? 8'd99 : {1'b0, i_val};
  assign w_tens = w_val / 8'd10;
  assign o_tens = ASC_ZERO + w_tens;
  assign o_ones = ASC_ZERO + (w_val - w_tens * 8'd10);

endmodule
`default_nettype wire

// File: rtl/uart_time_report.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_time_report : streams a frozen time snapshot as "HH:MM:SS.CC" + EOL
// to a UART TX core. Optional macro UART_AUTO_REPORT_EN: request on sec change.
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_time_report #(
  parameter int TERM_CRLF   = 1,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  wire                clk,
  input  wire                rst_n,
  input  wire                i_report_req,
  input  wire                i_auto_en,
  input  wire  [6:0]         i_msec,
  input  wire  [5:0]         i_sec,
  input  wire  [5:0]         i_min,
  input  wire  [5:0]         i_hour,
  uart_time_report_if.master tx,
  output logic               o_busy,
  output logic               o_report_done,
  output logic               o_timeout_err
);
  import uart_report_pkg::*;

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       LAST_IDX = (TERM_CRLF != 0) ? LAST_IDX_CRLF : LAST_IDX_LF;

  state_t           r_state;
  logic             r_pending;
  logic             r_busy;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;
  logic             r_report_done;
  logic             r_timeout_err;
  logic [3:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_hour, r_min, r_sec;
  logic [6:0]       r_msec;

  logic             w_req;
  logic [7:0]       w_byte;
  logic [7:0]       w_hour_t, w_hour_o, w_min_t, w_min_o;
  logic [7:0]       w_sec_t, w_sec_o, w_msec_t, w_msec_o;

`ifdef UART_AUTO_REPORT_EN
  logic [5:0] r_sec_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sec_prev <= 6'd0;
    else        r_sec_prev <= i_sec;
  end

  assign w_req = i_report_req | (i_auto_en & (i_sec != r_sec_prev));
`else
  logic w_unused_auto;
  assign w_unused_auto = i_auto_en;
  assign w_req         = i_report_req;
`endif

  bin2ascii2 u_b2a_hour (.i_val({1'b0, r_hour}), .o_tens(w_hour_t), .o_ones(w_hour_o));
  bin2ascii2 u_b2a_min  (.i_val({1'b0, r_min}),  .o_tens(w_min_t),  .o_ones(w_min_o));
  bin2ascii2 u_b2a_sec  (.i_val({1'b0, r_sec}),  .o_tens(w_sec_t),  .o_ones(w_sec_o));
  bin2ascii2 u_b2a_msec (.i_val(r_msec),         .o_tens(w_msec_t), .o_ones(w_msec_o));

  always_comb begin
    w_byte = ASC_LF;
    case (r_idx)
      4'd0:    w_byte = w_hour_t;
      4'd1:    w_byte = w_hour_o;
      4'd2:    w_byte = ASC_COLON;
      4'd3:    w_byte = w_min_t;
      4'd4:    w_byte = w_min_o;
      4'd5:    w_byte = ASC_COLON;
      4'd6:    w_byte = w_sec_t;
      4'd7:    w_byte = w_sec_o;
      4'd8:    w_byte = ASC_DOT;
      4'd9:    w_byte = w_msec_t;
      4'd10:   w_byte = w_msec_o;
      4'd11:   w_byte = (TERM_CRLF != 0) ? ASC_CR : ASC_LF;
      default: w_byte = ASC_LF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pending     <= 1'b0;
      r_busy        <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'd0;
      r_report_done <= 1'b0;
      r_timeout_err <= 1'b0;
      r_idx         <= 4'd0;
      r_cnt         <= '0;
      r_hour        <= 6'd0;
      r_min         <= 6'd0;
      r_sec         <= 6'd0;
      r_msec        <= 7'd0;
    end else begin
      r_tx_start    <= 1'b0;
      r_report_done <= 1'b0;
      r_timeout_err <= 1'b0;

      if (w_req && (r_state != S_IDLE)) r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          // Snapshot is taken on the request edge so later input changes never leak in
          if (w_req || r_pending) begin
            r_hour    <= i_hour;
            r_min     <= i_min;
            r_sec     <= i_sec;
            r_msec    <= i_msec;
            r_busy    <= 1'b1;
            r_idx     <= 4'd0;
            r_pending <= 1'b0;
            r_state   <= S_SNAP;
          end
        end
        S_SNAP, S_SEND: begin
          if (!tx.tx_busy) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= w_byte;
            r_cnt      <= '0;
            r_state    <= S_WAIT_DONE;
          end else begin
            r_state    <= S_SEND;
          end
        end
        S_WAIT_DONE: begin
          if (tx.tx_done) begin
            r_state <= S_NEXT;
          end else if (r_cnt == CNT_LAST) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_pending     <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_NEXT: begin
          if (r_idx == LAST_IDX) begin
            r_report_done <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_state <= S_SEND;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx.tx_start   = r_tx_start;
  assign tx.tx_data    = r_tx_data;
  assign o_busy        = r_busy;
  assign o_report_done = r_report_done;
  assign o_timeout_err = r_timeout_err;

endmodule
`default_nettype wire
